level_sequencer: RTL
====================

# level_sequencer

Parametrised progression FSM for puzzle levels with an arbitrary number of activation stages. It tracks the current map stage, advances or retreats when the sprite presses activate on a stage tile, and optionally inserts an animation phase before a forward transition. It also resets the level on sprite death and declares the win when the sprite reaches the goal region. It sits between the sprite controller (position, activate, death) and the map drawer / animator (redraw and animation handshakes).

## Interface
- NUM_STAGES, 4: number of activation tiles; stage index runs 0..NUM_STAGES (NUM_STAGES = final stage).
- X_W, 9: sprite X width.
- Y_W, 8: sprite Y width.
- SW, 3: stage index width; must satisfy 2^SW > NUM_STAGES.
- TILE, 6: activation tile edge in pixels.
- FWD_X, packed NUM_STAGES*X_W: tile k top-left X, in bits [k*X_W +: X_W].
- FWD_Y, packed NUM_STAGES*Y_W: tile k top-left Y.
- ANIM_MASK, NUM_STAGES bits: bit k=1 means transition k->k+1 requires animation.
- GOAL_X_MIN, GOAL_Y_MAX: win region is X >= GOAL_X_MIN and Y <= GOAL_Y_MAX, checked only in stage NUM_STAGES.

Ports:
- clock  in  1  system clock.
- resetn  in  1  synchronous, active-low reset.
- activate  in  1  sprite action key, level.
- spriteDead  in  1  sprite death, level.
- X  in  X_W  sprite X.
- Y  in  Y_W  sprite Y.
- doneRedraw  in  1  map drawer completion, level.
- doneAnimation  in  1  animator completion, level.
- drawMap  out  1  redraw request.
- startAnimation  out  1  one-cycle animation start pulse.
- stage  out  SW  current map stage.
- gameState  out  3  FSM state encoding.
- finished  out  1  high in FINISHED.

One clock; reset is synchronous and active-low.

## Operation
- States (gameState): REDRAW=0, PLAY=1, ANIMATE=2, FIN_DRAW=3, FINISHED=4; other encodings -> REDRAW.
- act_q: activate delayed one cycle. act_rise = activate & ~act_q. All tile triggers use act_rise only, never the activate level.
- Tile k hit: X >= FWD_X[k] and X <= FWD_X[k]+TILE-1, same test on Y. Sums are computed one bit wider to prevent wrap.
- REDRAW: drawMap = ~doneRedraw. Moves to PLAY on the first cycle doneRedraw=1.
- PLAY, priority order:
  - (1) spriteDead: stage<=0, go to REDRAW.
  - (2) stage<NUM_STAGES, act_rise and tile[stage] hit: stage<=stage+1. Go to ANIMATE if ANIM_MASK[stage], else REDRAW.
  - (3) stage>=1, act_rise and tile[stage-1] hit: stage<=stage-1, go to REDRAW. Backward moves never animate.
  - (4) stage==NUM_STAGES and goal hit: go to FIN_DRAW.
  - (5) Otherwise stay in PLAY.
- (2) and (3) cannot both fire. If two tiles overlap, forward wins.
- ANIMATE: startAnimation=1 only on the first cycle in the state, so the animator reads the new stage. Moves to REDRAW when doneAnimation=1. spriteDead is ignored here.
- FIN_DRAW: drawMap = ~doneRedraw, goes to FINISHED on doneRedraw.
- FINISHED: terminal; finished=1, drawMap=0. Only reset leaves it.
- spriteDead in REDRAW or FIN_DRAW is ignored. It is acted on at the next PLAY cycle.

## Timing
- Reset values: state=REDRAW, stage=0, act_q=1, startAnimation=0, finished=0. drawMap=1 unless doneRedraw is high.
- act_q resets to 1, so an activate held through reset does not trigger.
- drawMap is combinational from state and doneRedraw.
- stage, startAnimation and finished are registered.
- PLAY trigger at cycle t: stage and state update at t+1. drawMap is high at t+1 if the target is REDRAW. startAnimation is high exactly at t+1 if the target is ANIMATE.
- REDRAW with doneRedraw high on the entry cycle: drawMap=0 that cycle, and the state is PLAY on the next cycle (one-cycle minimum).
- resetn low on any cycle, mid-animation or mid-redraw included: all registers take reset values at the next edge. A pending doneAnimation or doneRedraw is discarded.
- Activate held across a redraw cannot retrigger. A new rising edge is required in PLAY.

## Test plan
Configuration: NUM_STAGES=3, tiles (120,156), (189,151), (177,213), ANIM_MASK=3'b100, goal X>=156, Y<=55.
- Reset, doneRedraw=1 after 5 cycles -> drawMap high 5 cycles, then PLAY, stage=0.
- X=122, Y=158, activate 0->1 -> next cycle stage=1, REDRAW. activate held high through doneRedraw -> PLAY with stage still 1.
- Stage 1, X=125, Y=161, activate rise -> stage=0 (backward). X=126, Y=158 rise -> no change (tile edge).
- Stage 2 at (180,214), activate rise -> ANIMATE, stage=3, startAnimation high exactly 1 cycle. doneAnimation -> REDRAW -> PLAY.
- Stage 3, X=160, Y=40 -> FIN_DRAW, doneRedraw -> FINISHED, finished=1. Later activate or spriteDead -> no change.
- Stage 2, spriteDead=1 together with a forward activate rise -> stage=0, REDRAW (death priority). resetn low during ANIMATE -> REDRAW, stage=0 next cycle.

Source files
------------

// File: rtl/level_sequencer.sv
// Level progression FSM: tracks map stage, steps on activation tiles, animates, redraws, declares win.
// Latency: stage/state/startAnimation/finished update one cycle after a PLAY trigger; drawMap is combinational.
// Backpressure: waits in REDRAW/FIN_DRAW for doneRedraw and in ANIMATE for doneAnimation; no other stalls.
module level_sequencer #(
   parameter int                          NUM_STAGES = 4,
   parameter int                          X_W        = 9,
   parameter int                          Y_W        = 8,
   parameter int                          SW         = 3,
   parameter int                          TILE       = 6,
   parameter logic [NUM_STAGES*X_W-1:0]   FWD_X      = {9'd220, 9'd160, 9'd100, 9'd40},
   parameter logic [NUM_STAGES*Y_W-1:0]   FWD_Y      = {8'd200, 8'd150, 8'd100, 8'd50},
   parameter logic [NUM_STAGES-1:0]       ANIM_MASK  = '0,
   parameter logic [X_W-1:0]              GOAL_X_MIN = 9'd300,
   parameter logic [Y_W-1:0]              GOAL_Y_MAX = 8'd40
) (
   input  logic           clock,
   input  logic           resetn,
   input  logic           activate,
   input  logic           spriteDead,
   input  logic [X_W-1:0] X,
   input  logic [Y_W-1:0] Y,
   input  logic           doneRedraw,
   input  logic           doneAnimation,
   output logic           drawMap,
   output logic           startAnimation,
   output logic [SW-1:0]  stage,
   output logic [2:0]     gameState,
   output logic           finished
);

   typedef enum logic [2:0] {
      S_REDRAW   = 3'd0,
      S_PLAY     = 3'd1,
      S_ANIMATE  = 3'd2,
      S_FIN_DRAW = 3'd3,
      S_FINISHED = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic [SW-1:0]   stage_q, stage_d;
   logic            act_q;
   logic            start_anim_q;
   logic            finished_q;

   logic [NUM_STAGES-1:0] tile_hit;
   logic            fwd_hit, bwd_hit, fwd_anim;
   logic            act_rise, last_stage, goal_hit;

   // Per-tile hit test; bounds are one bit wider so tile_x+TILE-1 cannot wrap.
   genvar k;
   generate
      for (k = 0; k < NUM_STAGES; k++) begin : g_tile
         logic [X_W:0] x_lo, x_hi;
         logic [Y_W:0] y_lo, y_hi;
         assign x_lo = {1'b0, FWD_X[k*X_W +: X_W]};
         assign x_hi = x_lo + (X_W+1)'(TILE - 1);
         assign y_lo = {1'b0, FWD_Y[k*Y_W +: Y_W]};
         assign y_hi = y_lo + (Y_W+1)'(TILE - 1);
         assign tile_hit[k] = ({1'b0, X} >= x_lo) && ({1'b0, X} <= x_hi) &&
                              ({1'b0, Y} >= y_lo) && ({1'b0, Y} <= y_hi);
      end
   endgenerate

   assign act_rise   = activate & ~act_q;
   assign last_stage = (stage_q == SW'(NUM_STAGES));
   assign goal_hit   = (X >= GOAL_X_MIN) && (Y <= GOAL_Y_MAX);

   // Select the forward tile (current stage) and backward tile (previous stage).
   always_comb begin
      fwd_hit  = 1'b0;
      bwd_hit  = 1'b0;
      fwd_anim = 1'b0;
      for (int i = 0; i < NUM_STAGES; i++) begin
         if (stage_q == SW'(i)) begin
            fwd_hit  = tile_hit[i];
            fwd_anim = ANIM_MASK[i];
         end
         if (stage_q == SW'(i + 1)) begin
            bwd_hit = tile_hit[i];
         end
      end
   end

   // Next-state, next-stage and redraw request; forward beats backward, death beats both.
   always_comb begin
      state_d = state_q;
      stage_d = stage_q;
      drawMap = 1'b0;
      case (state_q)
         S_REDRAW: begin
            drawMap = ~doneRedraw;
            if (doneRedraw) state_d = S_PLAY;
         end
         S_PLAY: begin
            if (spriteDead) begin
               stage_d = '0;
               state_d = S_REDRAW;
            end else if (act_rise && fwd_hit) begin
               stage_d = stage_q + 1'b1;
               state_d = fwd_anim ? S_ANIMATE : S_REDRAW;
            end else if (act_rise && bwd_hit) begin
               stage_d = stage_q - 1'b1;
               state_d = S_REDRAW;
            end else if (last_stage && goal_hit) begin
               state_d = S_FIN_DRAW;
            end
         end
         S_ANIMATE: begin
            if (doneAnimation) state_d = S_REDRAW;
         end
         S_FIN_DRAW: begin
            drawMap = ~doneRedraw;
            if (doneRedraw) state_d = S_FINISHED;
         end
         S_FINISHED: begin
            state_d = S_FINISHED;
         end
         default: begin
            state_d = S_REDRAW;
         end
      endcase
   end

   // State, stage, activate history and registered pulses; act_q resets high so a held key cannot trigger.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q      <= S_REDRAW;
         stage_q      <= '0;
         act_q        <= 1'b1;
         start_anim_q <= 1'b0;
         finished_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         stage_q      <= stage_d;
         act_q        <= activate;
         start_anim_q <= (state_d == S_ANIMATE) && (state_q != S_ANIMATE);
         finished_q   <= (state_d == S_FINISHED);
      end
   end

   assign startAnimation = start_anim_q;
   assign stage          = stage_q;
   assign gameState      = state_q;
   assign finished       = finished_q;

endmodule
